// File: rtl/shared_resource_arbiter_if.sv
// Request/grant bundle between the clients and the arbiter.
// The master side drives request/done; the slave (arbiter) side drives the grant.
interface shared_resource_arbiter_if #(
   parameter int NUM_REQUESTERS = 4,
   parameter int INDEX_WIDTH    = $clog2(NUM_REQUESTERS)
);
   logic [NUM_REQUESTERS-1:0] request;
   logic                      done;
   logic                      grant_valid;
   logic [NUM_REQUESTERS-1:0] grant_oh;
   logic [INDEX_WIDTH-1:0]    grant_idx;
   logic                      timeout;

   modport master (
      output request, done,
      input  grant_valid, grant_oh, grant_idx, timeout
   );

   modport slave (
      input  request, done,
      output grant_valid, grant_oh, grant_idx, timeout
   );
endinterface

// File: rtl/shared_resource_arbiter.sv
// Round-robin arbiter for one multi-cycle shared resource.
// Each grant is held until done, or force-released after MAX_HOLD cycles.
module shared_resource_arbiter #(
   parameter int NUM_REQUESTERS = 4,
   parameter int INDEX_WIDTH    = $clog2(NUM_REQUESTERS),
   parameter int MAX_HOLD       = 16
) (
   input logic                      clk,
   input logic                      reset,
   shared_resource_arbiter_if.slave bus
);
   localparam int HCNT_W = $clog2(MAX_HOLD);

   typedef enum logic {IDLE, GRANTED} state_t;

   state_t                    state;
   logic [INDEX_WIDTH-1:0]    ptr;
   logic [HCNT_W-1:0]         hcnt;

   logic                      found;
   logic [INDEX_WIDTH-1:0]    pos;
   logic [INDEX_WIDTH-1:0]    win_idx;
   logic [NUM_REQUESTERS-1:0] win_oh;
   logic [INDEX_WIDTH-1:0]    ptr_next;
   logic                      hold_limit;

   // Search starts at ptr and wraps; the first set request bit wins.
   always_comb begin
      found   = 1'b0;
      pos     = '0;
      win_idx = '0;
      win_oh  = '0;
      for (int k = 0; k < NUM_REQUESTERS; k++) begin
         pos = INDEX_WIDTH'((int'(ptr) + k) % NUM_REQUESTERS);
         if (!found && bus.request[pos]) begin
            found       = 1'b1;
            win_idx     = pos;
            win_oh[pos] = 1'b1;
         end
      end
      ptr_next   = (int'(win_idx) == NUM_REQUESTERS - 1) ? '0 : win_idx + INDEX_WIDTH'(1);
      hold_limit = (hcnt == HCNT_W'(MAX_HOLD - 1));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state           <= IDLE;
         ptr             <= '0;
         hcnt            <= '0;
         bus.grant_valid <= 1'b0;
         bus.grant_oh    <= '0;
         bus.grant_idx   <= '0;
         bus.timeout     <= 1'b0;
      end else begin
         bus.timeout <= 1'b0;
         case (state)
            IDLE: begin
               if (found) begin
                  state           <= GRANTED;
                  ptr             <= ptr_next;
                  hcnt            <= '0;
                  bus.grant_valid <= 1'b1;
                  bus.grant_oh    <= win_oh;
                  bus.grant_idx   <= win_idx;
               end
            end
            GRANTED: begin
               if (bus.done || hold_limit) begin
                  // done wins over the hold limit: a coinciding finish is a normal release
                  bus.timeout <= !bus.done;
                  if (found) begin
                     ptr           <= ptr_next;
                     hcnt          <= '0;
                     bus.grant_oh  <= win_oh;
                     bus.grant_idx <= win_idx;
                  end else begin
                     state           <= IDLE;
                     hcnt            <= '0;
                     bus.grant_valid <= 1'b0;
                     bus.grant_oh    <= '0;
                     bus.grant_idx   <= '0;
                  end
               end else begin
                  hcnt <= hcnt + HCNT_W'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_shared_resource_arbiter.sv
// Directed + randomized bench; a cycle-level owner/pointer reference model supplies every expectation.
module tb_shared_resource_arbiter;
   localparam int N  = 4;
   localparam int IW = 2;
   localparam int MH = 16;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   shared_resource_arbiter_if #(.NUM_REQUESTERS(N), .INDEX_WIDTH(IW)) bus();

   shared_resource_arbiter #(.NUM_REQUESTERS(N), .INDEX_WIDTH(IW), .MAX_HOLD(MH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: current owner (-1 = none), next search start, cycles owned so far.
   int m_owner = -1;
   int m_ptr   = 0;
   int m_held  = 0;
   bit m_to    = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
      else n_pass++;
   endtask

   function automatic int pick(input logic [N-1:0] r);
      logic [N-1:0] t;
      for (int k = 0; k < N; k++) begin
         t = r >> ((m_ptr + k) % N);
         if (t[0]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_owner = -1; m_ptr = 0; m_held = 0; m_to = 1'b0;
   endtask

   task automatic model_edge(input logic [N-1:0] r, input logic d);
      int w;
      bit forced;
      if (m_owner < 0) begin
         m_to = 1'b0;
         w = pick(r);
         if (w >= 0) begin m_owner = w; m_ptr = (w + 1) % N; m_held = 1; end
      end else begin
         forced = !d && (m_held == MH);
         m_to   = forced;
         if (d || forced) begin
            w = pick(r);
            if (w >= 0) begin m_owner = w; m_ptr = (w + 1) % N; m_held = 1; end
            else begin m_owner = -1; m_held = 0; end
         end else begin
            m_held++;
         end
      end
   endtask

   task automatic check_all(input string tag);
      logic [31:0] eoh;
      eoh = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
      chk({tag, ".valid"},   32'(bus.grant_valid), 32'(m_owner >= 0));
      chk({tag, ".oh"},      32'(bus.grant_oh),    eoh);
      chk({tag, ".idx"},     32'(bus.grant_idx),   (m_owner >= 0) ? 32'(m_owner) : 32'd0);
      chk({tag, ".timeout"}, 32'(bus.timeout),     32'(m_to));
   endtask

   // Inputs applied at the falling edge, sampled by the DUT at the rising edge,
   // outputs checked at the following falling edge.
   task automatic step(input logic [N-1:0] r, input logic d, input string tag);
      bus.request = r;
      bus.done    = d;
      @(posedge clk);
      model_edge(r, d);
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      reset = 1'b0;
      #1;
      model_reset();
      check_all(tag);
      @(negedge clk);
      reset = 1'b1;
   endtask

   initial begin
      bus.request = '0;
      bus.done    = 1'b0;
      do_reset("reset");

      // spurious done while idle
      step(4'b0000, 1'b1, "idle_done");
      step(4'b0000, 1'b1, "idle_done");

      // single requester, re-granted after done
      step(4'b0100, 1'b0, "single");
      chk("single_idx", 32'(bus.grant_idx), 32'd2);
      step(4'b0100, 1'b0, "single");
      step(4'b0100, 1'b0, "single");
      step(4'b0100, 1'b1, "single_regrant");
      chk("single_regrant_idx", 32'(bus.grant_idx), 32'd2);
      chk("single_regrant_valid", 32'(bus.grant_valid), 32'd1);
      step(4'b0000, 1'b1, "single_release");

      // full contention, done every second cycle
      do_reset("reset2");
      step(4'b1111, 1'b0, "contend");
      chk("contend_idx0", 32'(bus.grant_idx), 32'd0);
      for (int g = 1; g <= 4; g++) begin
         step(4'b1111, 1'b0, "contend");
         step(4'b1111, 1'b1, "contend");
         chk("contend_seq", 32'(bus.grant_idx), 32'(g % N));
         chk("contend_valid", 32'(bus.grant_valid), 32'd1);
      end

      // pointer wrap and skip
      step(4'b1000, 1'b1, "wrap");
      chk("wrap_idx3", 32'(bus.grant_idx), 32'd3);
      step(4'b0101, 1'b1, "wrap");
      chk("wrap_idx0", 32'(bus.grant_idx), 32'd0);
      step(4'b0101, 1'b1, "wrap");
      chk("wrap_idx2", 32'(bus.grant_idx), 32'd2);
      step(4'b0000, 1'b1, "wrap_release");

      // forced release after MAX_HOLD cycles, then done coinciding with the limit
      do_reset("reset3");
      step(4'b0011, 1'b0, "hold");
      for (int i = 0; i < MH - 1; i++) begin
         step(4'b0011, 1'b0, "hold");
         chk("hold_idx", 32'(bus.grant_idx), 32'd0);
      end
      step(4'b0011, 1'b0, "forced");
      chk("forced_timeout", 32'(bus.timeout), 32'd1);
      chk("forced_idx", 32'(bus.grant_idx), 32'd1);
      step(4'b0011, 1'b0, "after_forced");
      chk("timeout_one_cycle", 32'(bus.timeout), 32'd0);
      for (int i = 0; i < MH - 2; i++) step(4'b0011, 1'b0, "hold2");
      step(4'b0011, 1'b1, "done_at_limit");
      chk("done_at_limit_timeout", 32'(bus.timeout), 32'd0);
      chk("done_at_limit_idx", 32'(bus.grant_idx), 32'd0);

      // owner drops request, grant held until done
      for (int i = 0; i < 3; i++) begin
         step(4'b0000, 1'b0, "drop");
         chk("drop_held", 32'(bus.grant_valid), 32'd1);
      end
      step(4'b0000, 1'b1, "drop_done");
      chk("drop_idle", 32'(bus.grant_valid), 32'd0);

      // asynchronous reset mid-grant clears the pointer
      step(4'b1000, 1'b0, "pre_reset");
      chk("pre_reset_idx", 32'(bus.grant_idx), 32'd3);
      #2;
      do_reset("async_reset");
      step(4'b1010, 1'b0, "post_reset");
      chk("post_reset_idx", 32'(bus.grant_idx), 32'd1);

      // randomized traffic, alternating frequent and rare done, occasional reset
      for (int i = 0; i < 800; i++) begin
         logic [N-1:0] r;
         logic d;
         r = N'($urandom_range(0, (1 << N) - 1));
         if ((i / 100) % 2 == 0) d = ($urandom_range(0, 3) == 0);
         else d = ($urandom_range(0, 24) == 0);
         step(r, d, "rand");
         if ($urandom_range(0, 199) == 0) begin
            #2;
            do_reset("rand_reset");
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
